ahb_apb_bridge_p: RTL and testbench
===================================

Name: ahb_apb_bridge_p

Overview:
Parametrised successor to the fixed AHB-to-APB bridge.
- AHB-Lite slave on one side; an APB3 master driving NUM_SLV peripherals on the other.
- Adds per-slave pready wait states, pslverr mapped to an AHB two-cycle ERROR response, and parametrised address decode.
- Out-of-map addresses get an ERROR response and generate no APB cycle.
- Sits between the AHB interconnect and the APB peripheral cluster.

Parameters:
ADDR_W, 32, AHB/APB address width
DATA_W, 32, AHB/APB data width
NUM_SLV, 4, number of APB slaves (1..16)
BASE_ADDR, 32'h8000_0000, base of the APB window
SLV_AW, 12, log2 bytes per slave region; slave index = haddr[SLV_AW +: clog2(NUM_SLV)]
TIMEOUT_CYC, 255, ACCESS-phase timeout limit (used only with the optional feature)

Ports:
hclk  in  1  clock
hresetn  in  1  asynchronous active-low reset
hwrite  in  1  AHB write
hreadyin  in  1  AHB ready from bus
htrans  in  2  AHB transfer type
haddr  in  ADDR_W  AHB address
hwdata  in  DATA_W  AHB write data (data phase)
hreadyout  out  1  bridge ready
hresp  out  1  0=OKAY, 1=ERROR
hrdata  out  DATA_W  read data
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
pwrite  out  1  APB write
psel  out  NUM_SLV  one-hot slave select
penable  out  1  APB enable
prdata  in  NUM_SLV*DATA_W  per-slave read data, slave i at [i*DATA_W +: DATA_W]
pready  in  NUM_SLV  per-slave ready
pslverr  in  NUM_SLV  per-slave error

Behaviour:
- Reset (async, hresetn=0): state IDLE; hreadyout=1; hresp=0; hrdata, paddr and pwdata = 0; pwrite=0; psel=0; penable=0. Applies immediately mid-transfer; APB cycle abandoned.
- Accept condition: hreadyin=1 AND htrans[1]=1 (NONSEQ/SEQ) AND state is IDLE or ERR2. IDLE/BUSY htrans ignored.
- On accept: register haddr, hwrite, and decoded index.
- Address in range means BASE_ADDR <= haddr < BASE_ADDR + (NUM_SLV<<SLV_AW).
- Out-of-range accept goes to ERR1.
- In-range read goes to SETUP.
- In-range write goes to WLATCH.
- States and outputs:
  - IDLE: hreadyout=1, hresp=0.
  - WLATCH: hreadyout=0; capture hwdata into pwdata; next state SETUP.
  - SETUP: psel[idx]=1, penable=0, paddr and pwrite valid; next state ACCESS.
  - ACCESS: psel[idx]=1, penable=1.
    - pready[idx]=0: stay in ACCESS.
    - pready[idx]=1 and pslverr[idx]=1: go to ERR1.
    - pready[idx]=1 and pslverr[idx]=0: go to IDLE; on reads, hrdata is registered from prdata slice idx.
  - ERR1: hreadyout=0, hresp=1, psel=0; next state ERR2.
  - ERR2: hreadyout=1, hresp=1; accepts a new transfer like IDLE, else goes to IDLE.
- hreadyout=0, hresp=0 in WLATCH/SETUP/ACCESS. psel=0 and penable=0 outside SETUP/ACCESS. All outputs registered.
- Latency with zero-wait slave, counted from address-phase cycle T0:
  - Read: SETUP T1, ACCESS T2, hreadyout=1 with hrdata at T3.
  - Write: WLATCH T1, SETUP T2, ACCESS T3, hreadyout=1 at T4.
- Each pready wait cycle adds one cycle.
- Boundaries:
  - pready/pslverr from non-selected slaves are ignored.
  - pslverr is sampled only when pready=1.
  - hrdata holds its value until the next read completes; it is not updated on error.
  - paddr holds its value between transfers.
  - Back-to-back transfers: a transfer accepted in the completion IDLE cycle proceeds with no bubble.
  - The top in-range address (slave NUM_SLV-1, last byte) decodes valid; BASE_ADDR-1 and BASE_ADDR+(NUM_SLV<<SLV_AW) are errors.

Optional Feature:
Macro AHB_APB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entering ACCESS and increments each ACCESS cycle with pready[idx]=0.
  - On reaching TIMEOUT_CYC, the bridge drops psel/penable and goes to ERR1.
  - The counter resets to 0.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package ahb_apb_bridge_pkg: state encoding (IDLE, WLATCH, SETUP, ACCESS, ERR1, ERR2), HTRANS codes (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11), HRESP codes (OKAY=0, ERROR=1).
- One sub-module, apb_slv_decode: combinational range check plus index/one-hot generation from haddr, parametrised by ADDR_W, NUM_SLV, BASE_ADDR, SLV_AW.

Test Plan:
- Read, slave 2, zero-wait. haddr=32'h8000_2010, hwrite=0, htrans=NONSEQ, prdata slice2=32'hDEAD_BEEF. Expect psel=4'b0100; penable high in cycle T2; hreadyout=1 with hrdata=32'hDEAD_BEEF at T3.
- Write, slave 0, 3 wait states. haddr=32'h8000_0004, hwdata=32'h1234_5678 at T1, pready low 3 cycles. Expect pwdata=32'h1234_5678 and pwrite=1 from T2; ACCESS T3-T6; hreadyout=1 at T7.
- Out-of-range. haddr=32'h8000_4000. Expect no psel; ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), then IDLE.
- pslverr. Read slave 3 with pready=1, pslverr=1. Expect hrdata unchanged and two-cycle ERROR response.
- Back-to-back plus reset. Read slave 1 immediately followed by write slave 1: expect no idle bubble. Then assert hresetn=0 during ACCESS: expect psel=0, penable=0, hreadyout=1 within the same cycle.
- With AHB_APB_TIMEOUT_EN and TIMEOUT_CYC=8: pready held low. Expect ERROR response after 8 ACCESS cycles, psel deasserted.

Source files
------------

// File: rtl/ahb_apb_bridge_p_pkg.sv
// Shared types for the parametrised AHB-Lite to APB3 bridge: FSM state
// encoding, HTRANS/HRESP codes and a transfer-type helper.
package ahb_apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WLATCH = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridge_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Only NONSEQ/SEQ carry a real transfer; IDLE/BUSY are ignored.
  function automatic logic htrans_active(input logic [1:0] htrans);
    logic v;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: v = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  v = 1'b0;
      default:                   v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ahb_apb_bridge_p_if.sv
// Bus bundle for the bridge: AHB-Lite slave side plus APB3 master side.
// The slave modport is the bridge view, master is the surrounding system.
interface ahb_apb_bridge_p_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  logic                        hwrite;
  logic                        hreadyin;
  logic [1:0]                  htrans;
  logic [ADDR_W-1:0]           haddr;
  logic [DATA_W-1:0]           hwdata;
  logic                        hreadyout;
  logic                        hresp;
  logic [DATA_W-1:0]           hrdata;
  logic [ADDR_W-1:0]           paddr;
  logic [DATA_W-1:0]           pwdata;
  logic                        pwrite;
  logic [NUM_SLV-1:0]          psel;
  logic                        penable;
  logic [NUM_SLV*DATA_W-1:0]   prdata;
  logic [NUM_SLV-1:0]          pready;
  logic [NUM_SLV-1:0]          pslverr;

  modport slave (
    input  hwrite, hreadyin, htrans, haddr, hwdata, prdata, pready, pslverr,
    output hreadyout, hresp, hrdata, paddr, pwdata, pwrite, psel, penable
  );

  modport master (
    output hwrite, hreadyin, htrans, haddr, hwdata, prdata, pready, pslverr,
    input  hreadyout, hresp, hrdata, paddr, pwdata, pwrite, psel, penable
  );
endinterface

// File: rtl/ahb_apb_bridge_p_apb_slv_decode.sv
// Combinational APB window decode: range check against the slave window,
// slave index from haddr and the matching one-hot select.
module apb_slv_decode
  import ahb_apb_bridge_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                NUM_SLV   = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                SLV_AW    = 12,
  parameter int                IDX_W     = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
  input  logic [ADDR_W-1:0]  i_haddr,
  output logic               o_in_range,
  output logic [IDX_W-1:0]   o_idx,
  output logic [NUM_SLV-1:0] o_onehot
);

  // One extra bit so a window touching the top of the address space cannot wrap.
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WIN_HI = WIN_LO + ((ADDR_W + 1)'(NUM_SLV) << SLV_AW);

  // Range check, index extraction and one-hot select.
  always_comb begin
    o_in_range = ({1'b0, i_haddr} >= WIN_LO) && ({1'b0, i_haddr} < WIN_HI);
    o_idx      = i_haddr[SLV_AW +: IDX_W];
    o_onehot   = '0;
    if (o_in_range) begin
      o_onehot[o_idx] = 1'b1;
    end else begin
      o_onehot = '0;
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_p.sv
// AHB-Lite slave to APB3 master bridge with per-slave wait states, error mapping
// and parametrised decode. Optional ACCESS timeout: define AHB_APB_TIMEOUT_EN.
module ahb_apb_bridge_p
  import ahb_apb_bridge_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLV     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                SLV_AW      = 12,
  parameter int                TIMEOUT_CYC = 255
) (
  input logic              hclk,
  input logic              hresetn,
  ahb_apb_bridge_p_if.slave bus
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  if (NUM_SLV < 1 || NUM_SLV > 16 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("ahb_apb_bridge_p: NUM_SLV must be 1..16 and TIMEOUT_CYC at least 1");
  end

  bridge_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_haddr, w_haddr_nxt;
  logic                r_hwrite, w_hwrite_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [NUM_SLV-1:0]  r_oh, w_oh_nxt;
  logic                r_hreadyout, w_hreadyout_nxt;
  logic                r_hresp, w_hresp_nxt;
  logic [DATA_W-1:0]   r_hrdata, w_hrdata_nxt;
  logic [ADDR_W-1:0]   r_paddr, w_paddr_nxt;
  logic [DATA_W-1:0]   r_pwdata, w_pwdata_nxt;
  logic                r_pwrite, w_pwrite_nxt;
  logic [NUM_SLV-1:0]  r_psel, w_psel_nxt;
  logic                r_penable, w_penable_nxt;

  logic                w_dec_in_range;
  logic [IDX_W-1:0]    w_dec_idx;
  logic [NUM_SLV-1:0]  w_dec_oh;
  logic                w_accept;
  logic                w_sel_ready;
  logic                w_sel_err;

  apb_slv_decode #(
    .ADDR_W    (ADDR_W),
    .NUM_SLV   (NUM_SLV),
    .BASE_ADDR (BASE_ADDR),
    .SLV_AW    (SLV_AW),
    .IDX_W     (IDX_W)
  ) u_decode (
    .i_haddr    (bus.haddr),
    .o_in_range (w_dec_in_range),
    .o_idx      (w_dec_idx),
    .o_onehot   (w_dec_oh)
  );

  assign w_accept    = bus.hreadyin && htrans_active(bus.htrans) &&
                       ((r_state == ST_IDLE) || (r_state == ST_ERR2));
  // Only the selected slave's handshake matters; the rest are don't-care.
  assign w_sel_ready = bus.pready[r_idx];
  assign w_sel_err   = bus.pslverr[r_idx];

`ifdef AHB_APB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 255) ? 16 : 8;
  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic             w_tmo_hit;

  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // Wait-cycle counter: counts stalled ACCESS cycles, zero everywhere else.
  always_comb begin
    w_tmo_cnt_nxt = '0;
    if ((r_state == ST_ACCESS) && (w_state_nxt == ST_ACCESS)) begin
      w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
    end else begin
      w_tmo_cnt_nxt = '0;
    end
  end

  // Timeout counter register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= w_tmo_cnt_nxt;
    end
  end
`endif

  // Next state plus the held address/data/read-data values.
  always_comb begin
    w_state_nxt  = r_state;
    w_haddr_nxt  = r_haddr;
    w_hwrite_nxt = r_hwrite;
    w_idx_nxt    = r_idx;
    w_oh_nxt     = r_oh;
    w_hrdata_nxt = r_hrdata;
    w_paddr_nxt  = r_paddr;
    w_pwdata_nxt = r_pwdata;
    w_pwrite_nxt = r_pwrite;
    if (w_accept) begin
      w_haddr_nxt  = bus.haddr;
      w_hwrite_nxt = bus.hwrite;
      w_idx_nxt    = w_dec_idx;
      w_oh_nxt     = w_dec_oh;
      if (!w_dec_in_range) begin
        w_state_nxt = ST_ERR1;
      end else if (bus.hwrite) begin
        w_state_nxt = ST_WLATCH;
      end else begin
        w_state_nxt  = ST_SETUP;
        w_paddr_nxt  = bus.haddr;
        w_pwrite_nxt = 1'b0;
      end
    end else begin
      case (r_state)
        ST_IDLE:   w_state_nxt = ST_IDLE;
        ST_ERR2:   w_state_nxt = ST_IDLE;
        ST_ERR1:   w_state_nxt = ST_ERR2;
        ST_SETUP:  w_state_nxt = ST_ACCESS;
        ST_WLATCH: begin
          w_state_nxt  = ST_SETUP;
          w_pwdata_nxt = bus.hwdata;
          w_paddr_nxt  = r_haddr;
          w_pwrite_nxt = 1'b1;
        end
        ST_ACCESS: begin
          if (w_sel_ready) begin
            if (w_sel_err) begin
              w_state_nxt = ST_ERR1;
            end else begin
              w_state_nxt = ST_IDLE;
              if (!r_hwrite) begin
                w_hrdata_nxt = bus.prdata[int'(r_idx) * DATA_W +: DATA_W];
              end else begin
                w_hrdata_nxt = r_hrdata;
              end
            end
          end else begin
`ifdef AHB_APB_TIMEOUT_EN
            if (w_tmo_hit) begin
              w_state_nxt = ST_ERR1;
            end else begin
              w_state_nxt = ST_ACCESS;
            end
`else
            w_state_nxt = ST_ACCESS;
`endif
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Handshake outputs are a function of the state being entered, so they register cleanly.
  always_comb begin
    w_hreadyout_nxt = 1'b1;
    w_hresp_nxt     = HRESP_OKAY;
    w_psel_nxt      = '0;
    w_penable_nxt   = 1'b0;
    case (w_state_nxt)
      ST_IDLE: begin
        w_hreadyout_nxt = 1'b1;
      end
      ST_WLATCH: begin
        w_hreadyout_nxt = 1'b0;
      end
      ST_SETUP: begin
        w_hreadyout_nxt = 1'b0;
        w_psel_nxt      = w_oh_nxt;
      end
      ST_ACCESS: begin
        w_hreadyout_nxt = 1'b0;
        w_psel_nxt      = w_oh_nxt;
        w_penable_nxt   = 1'b1;
      end
      ST_ERR1: begin
        w_hreadyout_nxt = 1'b0;
        w_hresp_nxt     = HRESP_ERROR;
      end
      ST_ERR2: begin
        w_hresp_nxt = HRESP_ERROR;
      end
      default: begin
        w_hreadyout_nxt = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state     <= ST_IDLE;
      r_haddr     <= '0;
      r_hwrite    <= 1'b0;
      r_idx       <= '0;
      r_oh        <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_hrdata    <= '0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pwrite    <= 1'b0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_haddr     <= w_haddr_nxt;
      r_hwrite    <= w_hwrite_nxt;
      r_idx       <= w_idx_nxt;
      r_oh        <= w_oh_nxt;
      r_hreadyout <= w_hreadyout_nxt;
      r_hresp     <= w_hresp_nxt;
      r_hrdata    <= w_hrdata_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
    end
  end

  assign bus.hreadyout = r_hreadyout;
  assign bus.hresp     = r_hresp;
  assign bus.hrdata    = r_hrdata;
  assign bus.paddr     = r_paddr;
  assign bus.pwdata    = r_pwdata;
  assign bus.pwrite    = r_pwrite;
  assign bus.psel      = r_psel;
  assign bus.penable   = r_penable;

endmodule

// File: tb/tb_ahb_apb_bridge_p.sv
// Scoreboard bench for ahb_apb_bridge_p: directed AHB transfers push expected
// AHB responses and APB setup phases; independent monitors pop and compare.
module tb_ahb_apb_bridge_p;
  import ahb_apb_bridge_pkg::*;

  localparam int NUM_SLV = 4;

  logic hclk;
  logic hresetn;

  ahb_apb_bridge_p_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(NUM_SLV)) bus ();

  ahb_apb_bridge_p #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .NUM_SLV     (NUM_SLV),
    .BASE_ADDR   (32'h8000_0000),
    .SLV_AW      (12),
    .TIMEOUT_CYC (8)
  ) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  typedef struct {
    string       name;
    logic        resp;
    logic [31:0] rdata;
    int          done;
  } ahb_exp_t;

  typedef struct {
    string       name;
    logic [3:0]  psel;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
  } apb_exp_t;

  ahb_exp_t ahb_q[$];
  apb_exp_t apb_q[$];

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   cfg_waits = 0;
  logic cfg_err   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial begin
    forever begin
      @(posedge hclk);
      cyc++;
    end
  end

  // APB slave model: selected slave is ready after cfg_waits ACCESS cycles;
  // pslverr is high while not ready, and unselected slaves shout ready+error.
  initial begin
    int acc_cnt;
    acc_cnt     = 0;
    bus.pready  = '0;
    bus.pslverr = '0;
    bus.prdata  = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0F0F};
    forever begin
      @(negedge hclk);
      if (bus.penable && (bus.psel != 4'b0000)) begin
        for (int i = 0; i < NUM_SLV; i++) begin
          if (bus.psel[i]) begin
            bus.pready[i]  = (acc_cnt == cfg_waits);
            bus.pslverr[i] = (acc_cnt == cfg_waits) ? cfg_err : 1'b1;
          end else begin
            bus.pready[i]  = 1'b1;
            bus.pslverr[i] = 1'b1;
          end
        end
        acc_cnt++;
      end else begin
        acc_cnt     = 0;
        bus.pready  = '0;
        bus.pslverr = '0;
      end
    end
  end

  // AHB response monitor: each rising hreadyout completes one transfer.
  initial begin
    logic     prev_rdy;
    logic     prev_resp;
    ahb_exp_t e;
    prev_rdy  = 1'b1;
    prev_resp = 1'b0;
    forever begin
      @(negedge hclk);
      if (!hresetn) begin
        prev_rdy  = 1'b1;
        prev_resp = 1'b0;
      end else begin
        if (bus.hreadyout && !prev_rdy) begin
          if (ahb_q.size() == 0) begin
            chk("unexpected_ahb_resp", 64'd1, 64'd0);
          end else begin
            e = ahb_q.pop_front();
            chk({e.name, "_hresp"}, 64'(bus.hresp), 64'(e.resp));
            chk({e.name, "_hresp_prev"}, 64'(prev_resp), 64'(e.resp));
            chk({e.name, "_hrdata"}, 64'(bus.hrdata), 64'(e.rdata));
            chk({e.name, "_latency"}, 64'(cyc), 64'(e.done));
          end
        end
        prev_rdy  = bus.hreadyout;
        prev_resp = bus.hresp;
      end
    end
  end

  // APB monitor: each SETUP phase is one APB transfer presented by the bridge.
  initial begin
    apb_exp_t e;
    forever begin
      @(negedge hclk);
      if (hresetn && (bus.psel != 4'b0000) && !bus.penable) begin
        if (apb_q.size() == 0) begin
          chk("unexpected_apb_setup", 64'(bus.psel), 64'd0);
        end else begin
          e = apb_q.pop_front();
          chk({e.name, "_psel"}, 64'(bus.psel), 64'(e.psel));
          chk({e.name, "_paddr"}, 64'(bus.paddr), 64'(e.paddr));
          chk({e.name, "_pwrite"}, 64'(bus.pwrite), 64'(e.pwrite));
          if (e.pwrite) begin
            chk({e.name, "_pwdata"}, 64'(bus.pwdata), 64'(e.pwdata));
          end
        end
      end
    end
  end

  // Present one address phase as soon as the bridge is ready and record expectations.
  task automatic issue(input string name, input logic [31:0] addr, input logic wr,
                       input logic [31:0] wdata, input int waits, input logic err,
                       input logic apb, input logic [3:0] psel, input logic resp,
                       input logic [31:0] rdata, input int lat, output int t0);
    int       n;
    ahb_exp_t ae;
    apb_exp_t pe;
    n = 0;
    @(negedge hclk);
    while (!bus.hreadyout && n < 100) begin
      @(negedge hclk);
      n++;
    end
    if (n >= 100) begin
      chk({name, "_ready_timeout"}, 64'd1, 64'd0);
    end
    cfg_waits  = waits;
    cfg_err    = err;
    bus.haddr  = addr;
    bus.hwrite = wr;
    bus.htrans = HTRANS_NONSEQ;
    t0         = cyc;
    ae.name  = name;
    ae.resp  = resp;
    ae.rdata = rdata;
    ae.done  = cyc + lat;
    ahb_q.push_back(ae);
    if (apb) begin
      pe.name   = name;
      pe.psel   = psel;
      pe.paddr  = addr;
      pe.pwrite = wr;
      pe.pwdata = wdata;
      apb_q.push_back(pe);
    end
    @(posedge hclk);
    #1;
    bus.htrans = HTRANS_IDLE;
    bus.haddr  = 32'h0000_0000;
    bus.hwrite = 1'b0;
    bus.hwdata = wdata;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge hclk);
    while (((ahb_q.size() != 0) || !bus.hreadyout) && n < 200) begin
      @(negedge hclk);
      n++;
    end
    if (n >= 200) begin
      chk("drain_timeout", 64'd1, 64'd0);
    end
  endtask

  initial begin
    int ta, tb;
    int n;
    hresetn      = 1'b0;
    bus.hwrite   = 1'b0;
    bus.hreadyin = 1'b1;
    bus.htrans   = HTRANS_IDLE;
    bus.haddr    = 32'h0000_0000;
    bus.hwdata   = 32'h0000_0000;
    repeat (3) @(negedge hclk);
    chk("rst_hreadyout", 64'(bus.hreadyout), 64'd1);
    chk("rst_hresp", 64'(bus.hresp), 64'd0);
    chk("rst_hrdata", 64'(bus.hrdata), 64'd0);
    chk("rst_paddr", 64'(bus.paddr), 64'd0);
    chk("rst_pwdata", 64'(bus.pwdata), 64'd0);
    chk("rst_pwrite", 64'(bus.pwrite), 64'd0);
    chk("rst_psel", 64'(bus.psel), 64'd0);
    chk("rst_penable", 64'(bus.penable), 64'd0);
    hresetn = 1'b1;

    //    name         addr           wr    wdata          wt err   apb   psel     resp  rdata          lat
    issue("rd_s2",     32'h8000_2010, 1'b0, 32'h0000_0000, 0, 1'b0, 1'b1, 4'b0100, 1'b0, 32'hDEAD_BEEF, 3, ta);
    issue("wr_s0_w3",  32'h8000_0004, 1'b1, 32'h1234_5678, 3, 1'b0, 1'b1, 4'b0001, 1'b0, 32'hDEAD_BEEF, 7, ta);
    issue("oor_hi",    32'h8000_4000, 1'b0, 32'h0000_0000, 0, 1'b0, 1'b0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 2, ta);
    issue("oor_lo",    32'h7FFF_FFFF, 1'b0, 32'h0000_0000, 0, 1'b0, 1'b0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 2, ta);
    issue("slverr_s3", 32'h8000_3000, 1'b0, 32'h0000_0000, 1, 1'b1, 1'b1, 4'b1000, 1'b1, 32'hDEAD_BEEF, 5, ta);
    issue("rd_top",    32'h8000_3FFF, 1'b0, 32'h0000_0000, 0, 1'b0, 1'b1, 4'b1000, 1'b0, 32'h3333_3333, 3, ta);
    wait_idle();

    bus.haddr    = 32'h8000_0000;
    bus.htrans   = HTRANS_NONSEQ;
    bus.hreadyin = 1'b0;
    @(negedge hclk);
    chk("hreadyin_low_ignored", 64'(bus.hreadyout), 64'd1);
    bus.hreadyin = 1'b1;
    bus.htrans   = HTRANS_BUSY;
    @(negedge hclk);
    chk("busy_ignored", 64'(bus.hreadyout), 64'd1);
    bus.htrans = HTRANS_IDLE;

    issue("b2b_rd",    32'h8000_1008, 1'b0, 32'h0000_0000, 0, 1'b0, 1'b1, 4'b0010, 1'b0, 32'h1111_1111, 3, ta);
    issue("b2b_wr",    32'h8000_100C, 1'b1, 32'hA5A5_5A5A, 0, 1'b0, 1'b1, 4'b0010, 1'b0, 32'h1111_1111, 4, tb);
    chk("b2b_no_bubble", 64'(tb - ta), 64'd3);
    issue("err_then",  32'h8000_4000, 1'b0, 32'h0000_0000, 0, 1'b0, 1'b0, 4'b0000, 1'b1, 32'h1111_1111, 2, ta);
    issue("err2_acc",  32'h8000_0000, 1'b0, 32'h0000_0000, 0, 1'b0, 1'b1, 4'b0001, 1'b0, 32'h0000_0F0F, 3, tb);
    chk("err2_accept_cycle", 64'(tb - ta), 64'd2);
`ifdef AHB_APB_TIMEOUT_EN
    issue("timeout",   32'h8000_1000, 1'b0, 32'h0000_0000, 100, 1'b0, 1'b1, 4'b0010, 1'b1, 32'h0000_0F0F, 11, ta);
`endif
    wait_idle();

    issue("rst_rd",    32'h8000_2000, 1'b0, 32'h0000_0000, 5, 1'b0, 1'b1, 4'b0100, 1'b0, 32'hDEAD_BEEF, 8, ta);
    n = 0;
    while (!bus.penable && n < 20) begin
      @(negedge hclk);
      n++;
    end
    chk("rst_reach_access", 64'(bus.penable), 64'd1);
    #2;
    hresetn = 1'b0;
    #1;
    chk("midrst_psel", 64'(bus.psel), 64'd0);
    chk("midrst_penable", 64'(bus.penable), 64'd0);
    chk("midrst_hreadyout", 64'(bus.hreadyout), 64'd1);
    chk("midrst_hresp", 64'(bus.hresp), 64'd0);
    chk("midrst_paddr", 64'(bus.paddr), 64'd0);
    chk("midrst_hrdata", 64'(bus.hrdata), 64'd0);
    ahb_q.delete();
    apb_q.delete();
    @(negedge hclk);
    #2;
    hresetn = 1'b1;

    issue("post_rst",  32'h8000_0000, 1'b0, 32'h0000_0000, 0, 1'b0, 1'b1, 4'b0001, 1'b0, 32'h0000_0F0F, 3, ta);
    wait_idle();
    repeat (2) @(negedge hclk);
    chk("ahb_q_drained", 64'(ahb_q.size()), 64'd0);
    chk("apb_q_drained", 64'(apb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
